// File: rtl/threshold_pkg.sv
// Shared constants, FSM state type and width helper for the threshold level path.
package threshold_pkg;

  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } state_t;

  // One extra bit so a ladder threshold past the sample range is seen as a fail, never a wrap.
  function automatic int acc_width(input int sample_w);
    return sample_w + 1;
  endfunction

endpackage

// File: rtl/hold_decay_timer.sv
// Peak-hold register with a hold period followed by a one-step-per-period decay.
module hold_decay_timer
  import threshold_pkg::*;
#(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int DECAY_CYCLES = 2_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_level,
  output logic [LEVEL_W-1:0] peak
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int DECAY_W = $clog2(DECAY_CYCLES + 1);

  logic [HOLD_W-1:0]  hold_cnt;
  logic [DECAY_W-1:0] decay_cnt;

  // A qualifying load outranks a decay tick in the same cycle and restarts the decay count.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak      <= '0;
      hold_cnt  <= '0;
      decay_cnt <= '0;
    end else if (load && (load_level >= peak)) begin
      peak      <= load_level;
      hold_cnt  <= (load_level == '0) ? '0 : HOLD_W'(HOLD_CYCLES);
      decay_cnt <= '0;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end else if (peak != '0) begin
      if (decay_cnt == DECAY_W'(DECAY_CYCLES - 1)) begin
        peak      <= peak - LEVEL_W'(1);
        decay_cnt <= '0;
      end else begin
        decay_cnt <= decay_cnt + DECAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/threshold_level_hold.sv
// Accepts magnitude samples, quantises them on a linear threshold ladder one rung per
// cycle, and feeds the level into a peak-hold/decay stage that drives the segment decoders.
module threshold_level_hold
  import threshold_pkg::*;
#(
  parameter int SAMPLE_W     = 8,
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int DECAY_CYCLES = 2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] floor,
  input  logic [SAMPLE_W-1:0] step,
  output logic [LEVEL_W-1:0]  level,
  output logic                level_valid,
  output logic [LEVEL_W-1:0]  D,
  output state_t              state
);

  // Handshake: a sample transfers on a rising clk edge where sample_valid and
  // sample_ready are both high; sample/floor/step are captured on that edge only.

  localparam int ACC_W = acc_width(SAMPLE_W);

  logic [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0] step_q;
  logic [ACC_W-1:0]    acc;
  logic [LEVEL_W-1:0]  k;
  logic                scan_pass;

  assign scan_pass = (k != LEVEL_W'(LEVEL_MAX)) && !acc[ACC_W-1] &&
                     ({1'b0, sample_q} >= acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sample_ready <= 1'b1;
      level        <= '0;
      level_valid  <= 1'b0;
      sample_q     <= '0;
      step_q       <= '0;
      acc          <= '0;
      k            <= '0;
    end else begin
      level_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid && sample_ready) begin
            sample_q     <= sample;
            step_q       <= step;
            acc          <= ACC_W'(floor) + ACC_W'(step);
            k            <= '0;
            sample_ready <= 1'b0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (scan_pass) begin
            k   <= k + LEVEL_W'(1);
            acc <= acc + ACC_W'(step_q);
          end else begin
            // Level and its strobe are registered so they line up with the UPDATE cycle.
            level       <= k;
            level_valid <= 1'b1;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  hold_decay_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .DECAY_CYCLES(DECAY_CYCLES)
  ) u_hold_decay_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (state == UPDATE),
    .load_level(level),
    .peak      (D)
  );

endmodule
